// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback-port arbiter.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;

  // Writeback source identity, used for the age flag and round-robin pointer
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // One pending register write
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding slot for a writeback source. A request is taken when
// valid && ready; writes to x0 are accepted but never stored. The slot frees
// when granted, and may be refilled on that same edge.
module wb_hold_slot #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic              grant_i,
  output logic              ready_o,
  output logic              slot_v_o,
  output logic [REG_AW-1:0] slot_rd_o,
  output logic [XLEN-1:0]   slot_data_o,
  output logic              fill_o
);

  // Ready comes from slot state only; a stored fill needs a non-zero rd
  always_comb begin
    ready_o = !slot_v_o || grant_i;
    fill_o  = valid_i && ready_o && (rd_i != '0);
  end

  // Slot register: refill wins over drain when both happen on one edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_v_o    <= 1'b0;
      slot_rd_o   <= '0;
      slot_data_o <= '0;
    end else if (fill_o) begin
      slot_v_o    <= 1'b1;
      slot_rd_o   <= rd_i;
      slot_data_o <= data_i;
    end else if (grant_i) begin
      slot_v_o    <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between ALU and LSU writeback slots.
// Same-rd contention always goes to the older slot; different-rd contention
// goes to the LSU, or alternates when WB_RR_EN is defined.
module wb_port_arbiter #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [REG_AW-1:0]    alu_rd_i,
  input  logic [XLEN-1:0]      alu_data_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [REG_AW-1:0]    lsu_rd_i,
  input  logic [XLEN-1:0]      lsu_data_i,
  output logic [REG_AW-1:0]    write_reg_addr,
  output logic [XLEN-1:0]      write_reg_data,
  output logic                 wen,
  output logic [2**REG_AW-1:0] pending_o
);

  import wb_pkg::*;

  logic              alu_v, lsu_v;
  logic              alu_fill, lsu_fill;
  logic              grant_alu, grant_lsu;
  logic [REG_AW-1:0] alu_rd, lsu_rd;
  logic [XLEN-1:0]   alu_data, lsu_data;
  src_e              age_q;

  wb_hold_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_alu_slot (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (alu_valid_i),
    .rd_i       (alu_rd_i),
    .data_i     (alu_data_i),
    .grant_i    (grant_alu),
    .ready_o    (alu_ready_o),
    .slot_v_o   (alu_v),
    .slot_rd_o  (alu_rd),
    .slot_data_o(alu_data),
    .fill_o     (alu_fill)
  );

  wb_hold_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_lsu_slot (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (lsu_valid_i),
    .rd_i       (lsu_rd_i),
    .data_i     (lsu_data_i),
    .grant_i    (grant_lsu),
    .ready_o    (lsu_ready_o),
    .slot_v_o   (lsu_v),
    .slot_rd_o  (lsu_rd),
    .slot_data_o(lsu_data),
    .fill_o     (lsu_fill)
  );

`ifdef WB_RR_EN
  src_e rr_q;
  logic contested_diff;

  // Round-robin pointer flips to the loser after each different-rd contest
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= SRC_ALU;
    end else if (contested_diff) begin
      rr_q <= grant_alu ? SRC_LSU : SRC_ALU;
    end
  end

  assign contested_diff = alu_v && lsu_v && (alu_rd != lsu_rd);
`endif

  // Grant selection: single requester wins; same rd goes to the older slot
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (alu_v && lsu_v) begin
      if (alu_rd == lsu_rd) begin
        if (age_q == SRC_ALU) grant_alu = 1'b1;
        else                  grant_lsu = 1'b1;
      end else begin
`ifdef WB_RR_EN
        if (rr_q == SRC_ALU) grant_alu = 1'b1;
        else                 grant_lsu = 1'b1;
`else
        grant_lsu = 1'b1;
`endif
      end
    end else begin
      grant_alu = alu_v;
      grant_lsu = lsu_v;
    end
  end

  // Age flag: a slot that stays valid is older than one filled beside it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q <= SRC_LSU;
    end else if (alu_fill && lsu_fill) begin
      age_q <= SRC_LSU;
    end else if (alu_fill && lsu_v && !grant_lsu) begin
      age_q <= SRC_LSU;
    end else if (lsu_fill && alu_v && !grant_alu) begin
      age_q <= SRC_ALU;
    end
  end

  // Registered write stage; address and data hold when nothing is granted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wen            <= 1'b0;
      write_reg_addr <= '0;
      write_reg_data <= '0;
    end else if (grant_alu) begin
      wen            <= 1'b1;
      write_reg_addr <= alu_rd;
      write_reg_data <= alu_data;
    end else if (grant_lsu) begin
      wen            <= 1'b1;
      write_reg_addr <= lsu_rd;
      write_reg_data <= lsu_data;
    end else begin
      wen            <= 1'b0;
    end
  end

  // Pending mask covers both held slots and the staged write
  always_comb begin
    pending_o = '0;
    if (alu_v) pending_o[alu_rd] = 1'b1;
    if (lsu_v) pending_o[lsu_rd] = 1'b1;
    if (wen)   pending_o[write_reg_addr] = 1'b1;
    pending_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand-written
// sequences (back-to-back, async reset) and random traffic against a model.
module tb_wb_port_arbiter;

  import wb_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, wen;
  logic [4:0]  write_reg_addr;
  logic [31:0] write_reg_data;
  logic [31:0] pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_rd_i      (alu_rd),
    .alu_data_i    (alu_data),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_rd_i      (lsu_rd),
    .lsu_data_i    (lsu_data),
    .write_reg_addr(write_reg_addr),
    .write_reg_data(write_reg_data),
    .wen           (wen),
    .pending_o     (pending)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic        e_ar;
    logic        e_lr;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  // Reference model: each source holds at most one request, tagged with an
  // arrival number; lower number means earlier in program order.
  wb_req_t     m_req[2];
  logic        m_held[2];
  int          m_stamp[2];
  int          m_next_stamp;
  int          m_rr;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_wdata;

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      m_held[s]  = 1'b0;
      m_req[s]   = '0;
      m_stamp[s] = 0;
    end
    m_next_stamp = 0;
    m_rr    = 0;
    m_wen   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  function automatic int modelGrant();
    if (m_held[0] && m_held[1]) begin
      if (m_req[0].rd == m_req[1].rd) return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
`ifdef WB_RR_EN
      return m_rr;
`else
      return 1;
`endif
    end
    if (m_held[0]) return 0;
    if (m_held[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] modelPending();
    logic [31:0] p = '0;
    for (int s = 0; s < 2; s++) if (m_held[s]) p[m_req[s].rd] = 1'b1;
    if (m_wen) p[m_addr] = 1'b1;
    return p;
  endfunction

  task automatic modelStep();
    int   g;
    logic rdy0, rdy1, contested;
    g    = modelGrant();
    rdy0 = !m_held[0] || (g == 0);
    rdy1 = !m_held[1] || (g == 1);
    contested = m_held[0] && m_held[1] && (m_req[0].rd != m_req[1].rd);
    if (g >= 0) begin
      m_wen   = 1'b1;
      m_addr  = m_req[g].rd;
      m_wdata = m_req[g].data;
      m_held[g] = 1'b0;
      if (contested) m_rr = 1 - g;
    end else begin
      m_wen = 1'b0;
    end
    if (lsu_valid && rdy1 && lsu_rd != 5'd0) begin
      m_held[1] = 1'b1;
      m_req[1].rd = lsu_rd;
      m_req[1].data = lsu_data;
      m_stamp[1] = m_next_stamp++;
    end
    if (alu_valid && rdy0 && alu_rd != 5'd0) begin
      m_held[0] = 1'b1;
      m_req[0].rd = alu_rd;
      m_req[0].data = alu_data;
      m_stamp[0] = m_next_stamp++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    @(negedge clk);
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lr;
    lsu_data  = ld;
    #1;
  endtask

  task automatic checkModel(input string tag);
    int g;
    g = modelGrant();
    checkOutput({tag, "_alu_ready"}, 32'(alu_ready), 32'(!m_held[0] || g == 0));
    checkOutput({tag, "_lsu_ready"}, 32'(lsu_ready), 32'(!m_held[1] || g == 1));
    checkOutput({tag, "_wen"},       32'(wen),       32'(m_wen));
    checkOutput({tag, "_addr"},      32'(write_reg_addr), 32'(m_addr));
    checkOutput({tag, "_data"},      write_reg_data, m_wdata);
    checkOutput({tag, "_pending"},   pending,        modelPending());
  endtask

  task automatic addVec(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic e_ar, input logic e_lr, input logic e_wen,
                        input logic [4:0] e_addr, input logic [31:0] e_data,
                        input logic [31:0] e_pend);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.lv = lv; v.lr = lr; v.ld = ld;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_data = e_data; v.e_pend = e_pend;
    vecs.push_back(v);
  endtask

  task automatic fillTable();
    logic [4:0]  fa;
    logic [31:0] fd;
    // ALU only, rd=5
    addVec(1, 5, 32'hDEADBEEF, 0, 0, 0,  1, 1, 0, 0, 32'h0,        32'h0);
    addVec(0, 0, 0,            0, 0, 0,  1, 1, 0, 0, 32'h0,        32'h20);
    addVec(0, 0, 0,            0, 0, 0,  1, 1, 1, 5, 32'hDEADBEEF, 32'h20);
    addVec(0, 0, 0,            0, 0, 0,  1, 1, 0, 5, 32'hDEADBEEF, 32'h0);
    // Contention ALU rd3 vs LSU rd4
    addVec(1, 3, 32'h33,       1, 4, 32'h44, 1, 1, 0, 5, 32'hDEADBEEF, 32'h0);
`ifdef WB_RR_EN
    addVec(0, 0, 0, 0, 0, 0,  1, 0, 0, 5, 32'hDEADBEEF, 32'h18);
    addVec(0, 0, 0, 0, 0, 0,  1, 1, 1, 3, 32'h33,       32'h18);
    addVec(0, 0, 0, 0, 0, 0,  1, 1, 1, 4, 32'h44,       32'h10);
    addVec(0, 0, 0, 0, 0, 0,  1, 1, 0, 4, 32'h44,       32'h0);
    fa = 5'd4; fd = 32'h44;
`else
    addVec(0, 0, 0, 0, 0, 0,  0, 1, 0, 5, 32'hDEADBEEF, 32'h18);
    addVec(0, 0, 0, 0, 0, 0,  1, 1, 1, 4, 32'h44,       32'h18);
    addVec(0, 0, 0, 0, 0, 0,  1, 1, 1, 3, 32'h33,       32'h08);
    addVec(0, 0, 0, 0, 0, 0,  1, 1, 0, 3, 32'h33,       32'h0);
    fa = 5'd3; fd = 32'h33;
`endif
    // ALU held with rd2 becomes older than a later LSU rd2
    addVec(1, 2, 32'h0A02, 1, 6, 32'h0B06, 1, 1, 0, fa, fd,        32'h0);
    addVec(0, 0, 0,        1, 2, 32'h0C02, 0, 1, 0, fa, fd,        32'h44);
    addVec(0, 0, 0,        0, 0, 0,        1, 0, 1, 6, 32'h0B06,   32'h44);
    addVec(0, 0, 0,        0, 0, 0,        1, 1, 1, 2, 32'h0A02,   32'h04);
    addVec(0, 0, 0,        0, 0, 0,        1, 1, 1, 2, 32'h0C02,   32'h04);
    addVec(0, 0, 0,        0, 0, 0,        1, 1, 0, 2, 32'h0C02,   32'h0);
    // Write to x0 is swallowed
    addVec(1, 0, 32'hFFFFFFFF, 0, 0, 0,    1, 1, 0, 2, 32'h0C02,   32'h0);
    addVec(0, 0, 0,        0, 0, 0,        1, 1, 0, 2, 32'h0C02,   32'h0);
    addVec(0, 0, 0,        0, 0, 0,        1, 1, 0, 2, 32'h0C02,   32'h0);
    // LSU rd7 then ALU rd7: written in arrival order
    addVec(0, 0, 0,        1, 7, 32'h11,   1, 1, 0, 2, 32'h0C02,   32'h0);
    addVec(1, 7, 32'h22,   0, 0, 0,        1, 1, 0, 2, 32'h0C02,   32'h80);
    addVec(0, 0, 0,        0, 0, 0,        1, 1, 1, 7, 32'h11,     32'h80);
    addVec(0, 0, 0,        0, 0, 0,        1, 1, 1, 7, 32'h22,     32'h80);
    addVec(0, 0, 0,        0, 0, 0,        1, 1, 0, 7, 32'h22,     32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    modelReset();
    fillTable();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_wen",       32'(wen), 32'h0);
    checkOutput("rst_addr",      32'(write_reg_addr), 32'h0);
    checkOutput("rst_data",      write_reg_data, 32'h0);
    checkOutput("rst_pending",   pending, 32'h0);
    checkOutput("rst_alu_ready", 32'(alu_ready), 32'h1);
    checkOutput("rst_lsu_ready", 32'(lsu_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].lv, vecs[i].lr, vecs[i].ld);
      checkOutput($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
      checkOutput($sformatf("vec%0d_lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_lr));
      checkOutput($sformatf("vec%0d_wen", i),       32'(wen),       32'(vecs[i].e_wen));
      checkOutput($sformatf("vec%0d_addr", i),      32'(write_reg_addr), 32'(vecs[i].e_addr));
      checkOutput($sformatf("vec%0d_data", i),      write_reg_data, vecs[i].e_data);
      checkOutput($sformatf("vec%0d_pending", i),   pending,        vecs[i].e_pend);
      tick();
    end

    // Back-to-back ALU writes rd=1..8
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c < 8, 5'(c + 1), 32'h100 + 32'(c), 1'b0, 5'd0, 32'h0);
      checkOutput($sformatf("b2b%0d_alu_ready", c), 32'(alu_ready), 32'h1);
      checkOutput($sformatf("b2b%0d_wen", c), 32'(wen), 32'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) begin
        checkOutput($sformatf("b2b%0d_addr", c), 32'(write_reg_addr), 32'(c - 1));
        checkOutput($sformatf("b2b%0d_data", c), write_reg_data, 32'h100 + 32'(c - 2));
      end
      tick();
    end

    // Async reset with both slots occupied
    applyStimulus(1'b1, 5'd10, 32'hA0A0A0A0, 1'b1, 5'd10, 32'hB1B1B1B1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("ar_alu_ready", 32'(alu_ready), 32'h0);
    checkOutput("ar_pending",   pending, 32'h400);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("ar_pre_wen",  32'(wen), 32'h1);
    checkOutput("ar_pre_data", write_reg_data, 32'hB1B1B1B1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ar_now_wen",     32'(wen), 32'h0);
    checkOutput("ar_now_addr",    32'(write_reg_addr), 32'h0);
    checkOutput("ar_now_data",    write_reg_data, 32'h0);
    checkOutput("ar_now_pending", pending, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput($sformatf("ar_post%0d_wen", c), 32'(wen), 32'h0);
      checkModel($sformatf("ar_post%0d", c));
      tick();
    end

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      checkModel($sformatf("rnd%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
